// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a UART byte stream and
// writes it into an 18-bit-wide program memory while holding the CPU in reset.
// Frame: SYNC_BYTE, count high, count low, (count+1) x 3 word bytes, checksum.
// The modulo-256 sum of everything after the sync byte, the checksum byte
// included, must come to zero for the load to be accepted.

module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [9:0]  mem_addr,
  output logic [17:0] mem_data,
  output logic [3:0]  mem_we,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_H,
    CNT_L,
    W0,
    W1,
    W2,
    WR,
    CHK
  } loaderState_t;

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;

  loaderState_t state;
  logic [1:0]   countHi;
  logic [9:0]   wordsLeft;
  logic [7:0]   checksum;
  logic [23:0]  timer;

  logic [7:0]   sumNext;
  logic         lastWord;
  logic         timeoutHit;

  // Running checksum including the current byte, last-word flag and the
  // inter-byte timeout condition; a byte arriving on the final timer cycle wins.
  always_comb begin
    sumNext    = checksum + rx_data;
    lastWord   = (wordsLeft == 10'd0);
    timeoutHit = (state != IDLE) && !rx_valid && (timer == TIMEOUT_LAST);
  end

  // Loader FSM with registered outputs, inter-byte timer and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      countHi   <= 2'b00;
      wordsLeft <= 10'd0;
      checksum  <= 8'd0;
      timer     <= 24'd0;
      mem_addr  <= 10'd0;
      mem_data  <= 18'd0;
      mem_we    <= 4'b0000;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 4'b0000;
      done   <= 1'b0;

      if (state == IDLE || rx_valid) begin
        timer <= 24'd0;
      end else begin
        timer <= timer + 24'd1;
      end

      if (timeoutHit) begin
        error <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state     <= CNT_H;
              cpu_reset <= 1'b1;
              error     <= 1'b0;
              mem_addr  <= 10'd0;
              checksum  <= 8'd0;
              busy      <= 1'b1;
            end
          end

          CNT_H: begin
            if (rx_valid) begin
              checksum <= sumNext;
              if (|rx_data[7:2]) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                countHi <= rx_data[1:0];
                state   <= CNT_L;
              end
            end
          end

          CNT_L: begin
            if (rx_valid) begin
              checksum  <= sumNext;
              wordsLeft <= {countHi, rx_data};
              state     <= W0;
            end
          end

          W0: begin
            if (rx_valid) begin
              checksum        <= sumNext;
              mem_data[17:16] <= rx_data[1:0];
              state           <= W1;
            end
          end

          W1: begin
            if (rx_valid) begin
              checksum       <= sumNext;
              mem_data[15:8] <= rx_data;
              state          <= W2;
            end
          end

          W2: begin
            if (rx_valid) begin
              checksum      <= sumNext;
              mem_data[7:0] <= rx_data;
              mem_we        <= 4'b1111;
              state         <= WR;
            end
          end

          WR: begin
            mem_addr <= mem_addr + 10'd1;
            if (lastWord) begin
              if (rx_valid) begin
                checksum <= sumNext;
                busy     <= 1'b0;
                state    <= IDLE;
                if (sumNext == 8'd0) begin
                  cpu_reset <= 1'b0;
                  done      <= 1'b1;
                end else begin
                  error <= 1'b1;
                end
              end else begin
                state <= CHK;
              end
            end else begin
              wordsLeft <= wordsLeft - 10'd1;
              if (rx_valid) begin
                checksum        <= sumNext;
                mem_data[17:16] <= rx_data[1:0];
                state           <= W1;
              end else begin
                state <= W0;
              end
            end
          end

          CHK: begin
            if (rx_valid) begin
              checksum <= sumNext;
              busy     <= 1'b0;
              state    <= IDLE;
              if (sumNext == 8'd0) begin
                cpu_reset <= 1'b0;
                done      <= 1'b1;
              end else begin
                error <= 1'b1;
              end
            end
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: random frames are built from the framing rules,
// the expected write list and outcome are derived from the frame contents,
// and a negedge monitor compares every write pulse against that list.

module tb_prog_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [9:0]  mem_addr;
  logic [17:0] mem_data;
  logic [3:0]  mem_we;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int errorCount = 0;
  int checkCount = 0;
  int doneCount = 0;
  int writeCount = 0;

  logic [27:0] expWrites[$];
  logic [27:0] expEntry;
  logic [17:0] fixedWords[$];

  prog_loader #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT(24'(TOUT))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) doneCount++;
      if (mem_we != 4'b0000) begin
        writeCount++;
        checkOutput("wr_enable", {28'd0, mem_we}, 32'hF);
        if (expWrites.size() == 0) begin
          checkOutput("unexpected_wr", {28'd0, mem_we}, 32'h0);
        end else begin
          expEntry = expWrites.pop_front();
          checkOutput("wr_addr", {22'd0, mem_addr}, {22'd0, expEntry[27:18]});
          checkOutput("wr_data", {14'd0, mem_data}, {14'd0, expEntry[17:0]});
        end
      end
    end
  end

  // Present one byte for exactly one cycle (called at a falling edge), then idle.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pickGap(input bit burst);
    return burst ? 0 : int'($urandom_range(0, 2));
  endfunction

  // Build a complete frame, send it, and check the outcome.
  task automatic runLoad(input string name, input int count, input bit badChk,
                         input bit burst, input bit useFixed, input bit forceSync);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [17:0] w;
    int          doneBefore;
    int          writesBefore;
    doneBefore   = doneCount;
    writesBefore = writeCount;
    expWrites.delete();

    repeat (2) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      applyStimulus(b, pickGap(burst));
    end
    applyStimulus(SYNC, pickGap(burst));
    checkOutput({name, "_busy_in_load"}, {31'd0, busy}, 32'd1);
    checkOutput({name, "_cpurst_in_load"}, {31'd0, cpu_reset}, 32'd1);

    sum = 8'd0;
    b = 8'(count >> 8);
    sum += b;
    applyStimulus(b, pickGap(burst));
    b = 8'(count & 255);
    sum += b;
    applyStimulus(b, pickGap(burst));

    for (int i = 0; i <= count; i++) begin
      w = useFixed ? fixedWords[i] : 18'($urandom);
      if (forceSync && i == 0) w[15:8] = SYNC;
      expWrites.push_back({10'(i % 1024), w});
      b = {6'($urandom), w[17:16]};
      sum += b;
      applyStimulus(b, pickGap(burst));
      b = w[15:8];
      sum += b;
      applyStimulus(b, pickGap(burst));
      b = w[7:0];
      sum += b;
      applyStimulus(b, pickGap(burst));
    end
    b = 8'(8'd0 - sum) + 8'(badChk);
    applyStimulus(b, 0);
    repeat (3) @(negedge clk);

    checkOutput({name, "_done"}, 32'(doneCount - doneBefore), badChk ? 32'd0 : 32'd1);
    checkOutput({name, "_writes"}, 32'(writeCount - writesBefore), 32'(count + 1));
    checkOutput({name, "_pending"}, 32'(expWrites.size()), 32'd0);
    checkOutput({name, "_error"}, {31'd0, error}, {31'd0, badChk});
    checkOutput({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, badChk});
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    expWrites.delete();
  endtask

  initial begin
    int writesBefore;
    int doneBefore;

    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_outputs", {mem_we, 5'd0, mem_addr, 5'd0, cpu_reset, busy, done, error},
                32'd0);
    checkOutput("reset_mem_data", {14'd0, mem_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference two-word load, good and bad checksum.
    fixedWords.delete();
    fixedWords.push_back(18'h3ABCD);
    fixedWords.push_back(18'h00102);
    runLoad("basic", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    runLoad("badchk", 1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Invalid count high byte.
    writesBefore = writeCount;
    applyStimulus(SYNC, 0);
    applyStimulus(8'h04, 0);
    repeat (2) @(negedge clk);
    checkOutput("badcnt_error", {31'd0, error}, 32'd1);
    checkOutput("badcnt_busy", {31'd0, busy}, 32'd0);
    checkOutput("badcnt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("badcnt_writes", 32'(writeCount - writesBefore), 32'd0);

    // Randomized frames, gaps and checksum correctness.
    for (int n = 0; n < 5; n++) begin
      runLoad("rand", int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, n == 2);
    end
    runLoad("syncdata_burst", 5, 1'b0, 1'b1, 1'b0, 1'b1);

    // Stall mid-load until the inter-byte timer expires.
    writesBefore = writeCount;
    doneBefore   = doneCount;
    applyStimulus(SYNC, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    repeat (TOUT - 2) @(negedge clk);
    checkOutput("tout_not_early", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("tout_error", {31'd0, error}, 32'd1);
    checkOutput("tout_busy", {31'd0, busy}, 32'd0);
    checkOutput("tout_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("tout_writes", 32'(writeCount - writesBefore), 32'd0);
    checkOutput("tout_done", 32'(doneCount - doneBefore), 32'd0);

    // Full-size image, one byte per cycle.
    runLoad("full_burst", 1023, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bad load leaves the CPU in reset, then reset asserted in W1.
    runLoad("pre_reset_bad", 2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(SYNC, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h03, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outputs", {mem_we, 5'd0, mem_addr, 5'd0, cpu_reset, busy, done, error},
                32'd0);
    checkOutput("midrst_mem_data", {14'd0, mem_data}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_held_we", {28'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    runLoad("after_reset", 3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
